// File: rtl/param_mod_counter.sv
// Parametrised modulo-N up/down counter with enable prescaler, load/clear,
// cascade carry (tc), one-cycle wrap pulse and sticky wrap flag.
module param_mod_counter #(
   parameter int unsigned     WIDTH    = 4,
   parameter longint unsigned MODULUS  = 16,
   parameter int unsigned     PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             t,
   input  logic             up,
   input  logic             sclr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   // Terminal count held one bit wider so MODULUS = 2**WIDTH needs no special case
   localparam logic [WIDTH:0] Q_MAX = (WIDTH + 1)'(MODULUS - 1);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("param_mod_counter: WIDTH out of range");
   end
   if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("param_mod_counter: MODULUS out of range");
   end
   if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
      $error("param_mod_counter: PRESCALE out of range");
   end

   logic [PS_W-1:0]  ps;
   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   load_ext;
   logic [WIDTH-1:0] load_q;
   logic [WIDTH-1:0] q_next;
   logic             step;
   logic             at_max;
   logic             at_zero;

   assign q_ext    = {1'b0, q};
   assign load_ext = {1'b0, load_val};
   assign at_max   = (q_ext == Q_MAX);
   assign at_zero  = (q == '0);
   assign step     = t & (ps == PS_LAST);
   assign tc       = step & ((up & at_max) | (~up & at_zero));

   // Clamp out-of-range load values to the terminal count
   always_comb begin
      load_q = load_val;
      if (load_ext > Q_MAX) begin
         load_q = WIDTH'(Q_MAX);
      end
   end

   // Modulo successor / predecessor of q
   always_comb begin
      q_next = q;
      if (up) begin
         q_next = at_max ? '0 : WIDTH'(q_ext + (WIDTH + 1)'(1));
      end else begin
         q_next = at_zero ? WIDTH'(Q_MAX) : WIDTH'(q_ext - (WIDTH + 1)'(1));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q    <= '0;
         ps   <= '0;
         wrap <= 1'b0;
         ovf  <= 1'b0;
      end else if (sclr) begin
         q    <= '0;
         ps   <= '0;
         wrap <= 1'b0;
         ovf  <= 1'b0;
      end else if (load) begin
         q    <= load_q;
         ps   <= '0;
         wrap <= 1'b0;
         if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end else begin
         wrap <= tc;
         // A wrap on the same edge as ovf_clr leaves the flag set
         ovf  <= tc | (ovf & ~ovf_clr);
         if (t) begin
            ps <= step ? '0 : ps + PS_W'(1);
         end
         if (step) begin
            q <= q_next;
         end
      end
   end

endmodule

// File: tb/tb_param_mod_counter.sv
// Self-checking bench for param_mod_counter: decimal, prescaled, cascaded
// decade pair and full-range hex instances against a queued scoreboard.
module tb_param_mod_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       up = 1'b1;
   logic       sclr = 1'b0;
   logic       load = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic       t_a = 1'b0, t_p = 1'b0, t_u = 1'b0, t_h = 1'b0;

   logic [3:0] q_a, q_p, q_u, q_t, q_h;
   logic       tc_a, tc_p, tc_u, tc_t, tc_h;
   logic       wrap_a, wrap_p, wrap_u, wrap_t, wrap_h;
   logic       ovf_a, ovf_p, ovf_u, ovf_t, ovf_h;

   typedef struct packed {
      logic [3:0] q;
      logic       wrap;
      logic       ovf;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   param_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_a (
      .clk(clk), .reset(reset), .t(t_a), .up(up), .sclr(sclr), .load(load),
      .load_val(load_val), .ovf_clr(ovf_clr), .q(q_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a));

   param_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_p (
      .clk(clk), .reset(reset), .t(t_p), .up(up), .sclr(sclr), .load(load),
      .load_val(load_val), .ovf_clr(ovf_clr), .q(q_p), .tc(tc_p), .wrap(wrap_p), .ovf(ovf_p));

   param_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_units (
      .clk(clk), .reset(reset), .t(t_u), .up(up), .sclr(sclr), .load(load),
      .load_val(load_val), .ovf_clr(ovf_clr), .q(q_u), .tc(tc_u), .wrap(wrap_u), .ovf(ovf_u));

   param_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_tens (
      .clk(clk), .reset(reset), .t(tc_u), .up(up), .sclr(sclr), .load(load),
      .load_val(load_val), .ovf_clr(ovf_clr), .q(q_t), .tc(tc_t), .wrap(wrap_t), .ovf(ovf_t));

   param_mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_h (
      .clk(clk), .reset(reset), .t(t_h), .up(up), .sclr(sclr), .load(load),
      .load_val(load_val), .ovf_clr(ovf_clr), .q(q_h), .tc(tc_h), .wrap(wrap_h), .ovf(ovf_h));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sync_clear();
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      #1 reset = 1'b0;
      #1;
      n_checks++;
      if ({q_a, q_p, q_u, q_t, q_h} !== 20'd0 || {wrap_a, ovf_a, wrap_h, ovf_h} !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_state: q_a=%0d q_h=%0d wrap_a=%b ovf_a=%b, expected all 0",
                  q_a, q_h, wrap_a, ovf_a);
      end
      t_a = 1'b1;
      tick();
      tick();
      n_checks++;
      if (q_a !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_hold: q_a=%0d, expected 0", q_a);
      end
      reset = 1'b1;
      for (int i = 1; i <= 5; i++) sb.push_back('{q: 4'(i), wrap: 1'b0, ovf: 1'b0});
      for (int i = 1; i <= 5; i++) begin
         tick();
         e = sb.pop_front();
         n_checks++;
         if (q_a !== e.q || wrap_a !== e.wrap || ovf_a !== e.ovf) begin
            n_fail++;
            $display("FAIL reset_count[%0d]: q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                     i, q_a, wrap_a, ovf_a, e.q, e.wrap, e.ovf);
         end
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (q_a !== 4'd0 || wrap_a !== 1'b0 || ovf_a !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: q=%0d wrap=%b ovf=%b, expected 0 0 0", q_a, wrap_a, ovf_a);
      end
      tick();
      n_checks++;
      if (q_a !== 4'd0) begin
         n_fail++;
         $display("FAIL async_reset_hold: q=%0d, expected 0", q_a);
      end
      t_a = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_up_wrap();
      exp_t e;
      t_a = 1'b1;
      up = 1'b1;
      for (int i = 1; i <= 9; i++) sb.push_back('{q: 4'(i), wrap: 1'b0, ovf: 1'b0});
      for (int i = 1; i <= 9; i++) begin
         tick();
         e = sb.pop_front();
         n_checks++;
         if (q_a !== e.q || wrap_a !== e.wrap || ovf_a !== e.ovf) begin
            n_fail++;
            $display("FAIL up_count[%0d]: q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                     i, q_a, wrap_a, ovf_a, e.q, e.wrap, e.ovf);
         end
      end
      n_checks++;
      if (tc_a !== 1'b1) begin
         n_fail++;
         $display("FAIL up_tc: tc=%b, expected 1", tc_a);
      end
      sb.push_back('{q: 4'd0, wrap: 1'b1, ovf: 1'b1});
      sb.push_back('{q: 4'd0, wrap: 1'b0, ovf: 1'b1});
      sb.push_back('{q: 4'd0, wrap: 1'b0, ovf: 1'b0});
      for (int i = 0; i < 3; i++) begin
         if (i == 1) t_a = 1'b0;
         if (i == 2) ovf_clr = 1'b1;
         tick();
         ovf_clr = 1'b0;
         e = sb.pop_front();
         n_checks++;
         if (q_a !== e.q || wrap_a !== e.wrap || ovf_a !== e.ovf) begin
            n_fail++;
            $display("FAIL up_wrap[%0d]: q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                     i, q_a, wrap_a, ovf_a, e.q, e.wrap, e.ovf);
         end
      end
   endtask

   task automatic test_down_wrap();
      exp_t e;
      up = 1'b0;
      t_a = 1'b1;
      #1;
      n_checks++;
      if (tc_a !== 1'b1) begin
         n_fail++;
         $display("FAIL down_tc: tc=%b, expected 1", tc_a);
      end
      sb.push_back('{q: 4'd9, wrap: 1'b1, ovf: 1'b1});
      sb.push_back('{q: 4'd8, wrap: 1'b0, ovf: 1'b1});
      sb.push_back('{q: 4'd7, wrap: 1'b0, ovf: 1'b1});
      sb.push_back('{q: 4'd8, wrap: 1'b0, ovf: 1'b1});
      sb.push_back('{q: 4'd9, wrap: 1'b0, ovf: 1'b1});
      sb.push_back('{q: 4'd0, wrap: 1'b1, ovf: 1'b1});
      for (int i = 0; i < 6; i++) begin
         if (i == 3) up = 1'b1;
         tick();
         e = sb.pop_front();
         n_checks++;
         if (q_a !== e.q || wrap_a !== e.wrap || ovf_a !== e.ovf) begin
            n_fail++;
            $display("FAIL down_dir[%0d]: q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                     i, q_a, wrap_a, ovf_a, e.q, e.wrap, e.ovf);
         end
      end
      t_a = 1'b0;
      sync_clear();
      n_checks++;
      if (q_a !== 4'd0 || wrap_a !== 1'b0 || ovf_a !== 1'b0) begin
         n_fail++;
         $display("FAIL sclr_clears: q=%0d wrap=%b ovf=%b, expected 0 0 0", q_a, wrap_a, ovf_a);
      end
   endtask

   task automatic test_load_clear();
      exp_t e;
      bit         ld_v[7] = '{1, 1, 1, 1, 0, 1, 0};
      bit         sc_v[7] = '{0, 1, 0, 0, 0, 0, 0};
      bit         t_v[7]  = '{0, 0, 1, 1, 1, 1, 0};
      logic [3:0] lv_v[7] = '{4'd12, 4'd3, 4'd4, 4'd9, 4'd9, 4'd2, 4'd15};
      logic [3:0] eq_v[7] = '{4'd9, 4'd0, 4'd4, 4'd9, 4'd0, 4'd2, 4'd2};
      bit         ew_v[7] = '{0, 0, 0, 0, 1, 0, 0};
      bit         eo_v[7] = '{0, 0, 0, 0, 1, 1, 1};
      for (int i = 0; i < 7; i++) sb.push_back('{q: eq_v[i], wrap: ew_v[i], ovf: eo_v[i]});
      for (int i = 0; i < 7; i++) begin
         load = ld_v[i];
         sclr = sc_v[i];
         t_a = t_v[i];
         load_val = lv_v[i];
         tick();
         e = sb.pop_front();
         n_checks++;
         if (q_a !== e.q || wrap_a !== e.wrap || ovf_a !== e.ovf) begin
            n_fail++;
            $display("FAIL load_clear[%0d]: q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                     i, q_a, wrap_a, ovf_a, e.q, e.wrap, e.ovf);
         end
      end
      load = 1'b0;
      sclr = 1'b0;
      t_a = 1'b0;
      load_val = 4'd0;
      sync_clear();
   endtask

   task automatic test_prescale();
      exp_t e;
      int   en = 0;
      int   tc_seen = 0;
      logic tc_exp;
      logic ovf_exp = 1'b0;
      up = 1'b1;
      sync_clear();
      for (int i = 0; i < 36; i++) begin
         t_p = (i == 4 || i == 5) ? 1'b0 : 1'b1;
         #1;
         tc_exp = t_p && (en % 3 == 2) && ((en / 3) % 10 == 9);
         n_checks++;
         if (tc_p !== tc_exp) begin
            n_fail++;
            $display("FAIL prescale_tc[%0d]: tc=%b, expected %b", i, tc_p, tc_exp);
         end
         if (tc_p === 1'b1) tc_seen++;
         if (t_p) en++;
         ovf_exp = ovf_exp | tc_exp;
         sb.push_back('{q: 4'((en / 3) % 10), wrap: tc_exp, ovf: ovf_exp});
         tick();
         e = sb.pop_front();
         n_checks++;
         if (q_p !== e.q || wrap_p !== e.wrap || ovf_p !== e.ovf) begin
            n_fail++;
            $display("FAIL prescale[%0d]: q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                     i, q_p, wrap_p, ovf_p, e.q, e.wrap, e.ovf);
         end
      end
      t_p = 1'b0;
      n_checks++;
      if (tc_seen != 1) begin
         n_fail++;
         $display("FAIL prescale_tc_count: tc high %0d cycles, expected 1", tc_seen);
      end
   endtask

   task automatic test_cascade();
      exp_t eu, et;
      int   tens_wraps = 0;
      up = 1'b1;
      sync_clear();
      t_u = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         sb.push_back('{q: 4'(i % 10), wrap: (i % 10 == 0), ovf: (i >= 10)});
         sb.push_back('{q: 4'((i / 10) % 10), wrap: (i == 100), ovf: (i >= 100)});
         tick();
         if (wrap_t === 1'b1) tens_wraps++;
         eu = sb.pop_front();
         et = sb.pop_front();
         n_checks++;
         if (q_u !== eu.q || wrap_u !== eu.wrap || ovf_u !== eu.ovf ||
             q_t !== et.q || wrap_t !== et.wrap || ovf_t !== et.ovf) begin
            n_fail++;
            $display("FAIL cascade[%0d]: units=%0d/%b/%b tens=%0d/%b/%b, expected units=%0d/%b/%b tens=%0d/%b/%b",
                     i, q_u, wrap_u, ovf_u, q_t, wrap_t, ovf_t,
                     eu.q, eu.wrap, eu.ovf, et.q, et.wrap, et.ovf);
         end
      end
      t_u = 1'b0;
      tick();
      n_checks++;
      if (tens_wraps != 1 || wrap_t !== 1'b0) begin
         n_fail++;
         $display("FAIL cascade_tens_wrap: pulses=%0d wrap_now=%b, expected 1 and 0", tens_wraps, wrap_t);
      end
   endtask

   task automatic test_full_range();
      exp_t e;
      up = 1'b1;
      sync_clear();
      t_h = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         if (i == 17) up = 1'b0;
         #1;
         n_checks++;
         if (tc_h !== (i == 16 || i == 17)) begin
            n_fail++;
            $display("FAIL hex_tc[%0d]: tc=%b, expected %b", i, tc_h, (i == 16 || i == 17));
         end
         if (i == 17) sb.push_back('{q: 4'd15, wrap: 1'b1, ovf: 1'b1});
         else sb.push_back('{q: 4'(i % 16), wrap: (i == 16), ovf: (i >= 16)});
         tick();
         e = sb.pop_front();
         n_checks++;
         if (q_h !== e.q || wrap_h !== e.wrap || ovf_h !== e.ovf) begin
            n_fail++;
            $display("FAIL hex[%0d]: q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                     i, q_h, wrap_h, ovf_h, e.q, e.wrap, e.ovf);
         end
      end
      t_h = 1'b0;
      up = 1'b1;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_load_clear();
      test_prescale();
      test_cascade();
      test_full_range();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
